inst_decode: RTL and testbench
==============================

Name: inst_decode

Overview:
- Consumer end of the IF/ID interface: accepts if_id_instr/if_id_NPC from the fetch stage every cycle.
- Holds the 32x32 register file and decodes fields into the ID/EX pipeline register.
- Resolves branches in ID and drives PCSrc/Ex_NPC back to fetch.
- Squashes wrong-path instructions after a taken branch.

Parameters:
- FLUSH_CYCLES, 2, number of instructions squashed after a taken branch (1..3)
- PC_W, 10, instruction-address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- if_id_instr  in  32  instruction from fetch
- if_id_NPC  in  PC_W  PC+1 of that instruction
- wb_en  in  1  register-file write enable
- wb_addr  in  5  write register
- wb_data  in  32  write data
- PCSrc  out  1  redirect fetch (registered)
- Ex_NPC  out  PC_W  redirect target (registered)
- id_ex_valid  out  1  ID/EX holds a live instruction
- id_ex_opcode  out  6  instr[31:26]
- id_ex_funct  out  6  instr[5:0]
- id_ex_rs_val  out  32  rs operand
- id_ex_rt_val  out  32  rt operand
- id_ex_imm  out  32  sign-extended instr[15:0]
- id_ex_rd  out  5  destination register
- id_ex_NPC  out  PC_W  pass-through NPC
- id_ex_illegal  out  1  undefined opcode flag

Behaviour:
- Fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0], jump target[9:0].
- Opcodes:
  - 0 = R-type
  - 1 = addi
  - 2 = lw
  - 3 = sw
  - 4 = bz (taken if rs==0)
  - 5 = bnz (taken if rs!=0)
  - 6 = b (unconditional)
  - 7..63 = illegal
- Destination: R-type → rd; addi/lw → rt; sw/bz/bnz/b/illegal → 0.
- Register file:
  - 32x32; r0 reads 0 and writes to it are ignored.
  - Write on rising clk when wb_en=1.
  - Same-cycle bypass: if wb_en and wb_addr==rs (or rt) and wb_addr!=0, the read returns wb_data.
- Branch targets:
  - bz/bnz: if_id_NPC + imm[9:0], modulo 2^PC_W (wraps).
  - b: instr[9:0].
  - Compare uses the bypassed rs value.
- ID/EX register: all id_ex_* outputs update every rising edge (no stall); latency 1 cycle from if_id_* to id_ex_*.
- Squash logic:
  - flush_cnt counts 0..FLUSH_CYCLES.
  - Cycle is "live" iff flush_cnt==0.
  - Live taken branch at edge: PCSrc←1, Ex_NPC←target, flush_cnt←FLUSH_CYCLES.
  - Otherwise: PCSrc←0; Ex_NPC holds; flush_cnt decrements if nonzero.
  - PCSrc is high for exactly one cycle per taken branch.
- Squashed-cycle effects:
  - id_ex_valid←0, id_ex_rd←0, id_ex_illegal←0.
  - A branch in a squashed cycle is ignored: no PCSrc, counter still decrements.
- Live cycle: id_ex_valid←1. A live branch itself is valid (EX treats it as a no-op).
- Illegal opcode (live): id_ex_illegal←1, id_ex_rd←0, no redirect.
- Reset (asserted at any time, including mid-flush):
  - All outputs 0; flush_cnt 0; all 32 registers 0.
  - First cycle after release is live.

Test Plan:
- Reset: drive rst=0 mid-flush → all outputs 0 immediately; after release, addi r1,r0,5 at NPC=3 → next edge id_ex_valid=1, id_ex_rd=1, id_ex_imm=5, id_ex_NPC=3.
- Writeback/bypass: wb r2=0xDEADBEEF in the same cycle as R-type rs=2 → id_ex_rs_val=0xDEADBEEF; write to r0 → reads stay 0.
- bz taken: r3=0, bz rs=3 imm=0x0004, NPC=0x3FE → PCSrc=1 for one cycle, Ex_NPC=0x002 (wrap); next 2 instructions id_ex_valid=0; third valid.
- bnz not taken / b: bnz with rs=0 → PCSrc stays 0, no squash; b target 0x155 → Ex_NPC=0x155.
- Branch in shadow: taken b followed immediately by another b → only the first redirects; PCSrc asserts once.
- Illegal opcode 0x3F live → id_ex_illegal=1, id_ex_rd=0, PCSrc=0; sign-extension check: imm 0x8000 → id_ex_imm=0xFFFF8000.

Source files
------------

// File: rtl/inst_decode.sv
// inst_decode: ID stage -- register file, field decode into ID/EX, branch resolution and wrong-path squash.
// Ports:
//   clk, rst (async, active-low)
//   if_id_instr, if_id_NPC           instruction and PC+1 from fetch
//   wb_en, wb_addr, wb_data          register-file write port (bypassed to same-cycle reads)
//   PCSrc, Ex_NPC                    registered redirect request and target back to fetch
//   id_ex_*                          ID/EX pipeline register contents
module inst_decode #(
    parameter int FLUSH_CYCLES = 2,
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     if_id_instr,
    input  logic [PC_W-1:0] if_id_NPC,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [31:0]     wb_data,
    output logic            PCSrc,
    output logic [PC_W-1:0] Ex_NPC,
    output logic            id_ex_valid,
    output logic [5:0]      id_ex_opcode,
    output logic [5:0]      id_ex_funct,
    output logic [31:0]     id_ex_rs_val,
    output logic [31:0]     id_ex_rt_val,
    output logic [31:0]     id_ex_imm,
    output logic [4:0]      id_ex_rd,
    output logic [PC_W-1:0] id_ex_NPC,
    output logic            id_ex_illegal
);
    logic [31:0]     regs [32];
    logic [1:0]      flush_cnt;
    logic [5:0]      opcode;
    logic [4:0]      rs, rt, rd, dest;
    logic [31:0]     rs_val, rt_val, imm;
    logic            live, illegal, taken;
    logic [PC_W-1:0] offset, target;

    always_comb begin
        opcode  = if_id_instr[31:26];
        rs      = if_id_instr[25:21];
        rt      = if_id_instr[20:16];
        rd      = if_id_instr[15:11];
        imm     = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
        // r0 is forced to zero here so bypass from a write to r0 can never leak through
        rs_val  = (rs == 5'd0) ? 32'd0 : (wb_en && wb_addr == rs) ? wb_data : regs[rs];
        rt_val  = (rt == 5'd0) ? 32'd0 : (wb_en && wb_addr == rt) ? wb_data : regs[rt];
        live    = (flush_cnt == 2'd0);
        illegal = (opcode > 6'd6);
        dest    = (opcode == 6'd0) ? rd : (opcode == 6'd1 || opcode == 6'd2) ? rt : 5'd0;
        taken   = live && ((opcode == 6'd4 && rs_val == 32'd0) ||
                           (opcode == 6'd5 && rs_val != 32'd0) ||
                           (opcode == 6'd6));
        // the same low 10 bits serve as branch offset and absolute jump target
        offset  = PC_W'(if_id_instr[9:0]);
        target  = (opcode == 6'd6) ? offset : if_id_NPC + offset;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt     <= '0;
            PCSrc         <= 1'b0;
            Ex_NPC        <= '0;
            id_ex_valid   <= 1'b0;
            id_ex_opcode  <= '0;
            id_ex_funct   <= '0;
            id_ex_rs_val  <= '0;
            id_ex_rt_val  <= '0;
            id_ex_imm     <= '0;
            id_ex_rd      <= '0;
            id_ex_NPC     <= '0;
            id_ex_illegal <= 1'b0;
        end else begin
            PCSrc         <= taken;
            if (taken) Ex_NPC <= target;
            flush_cnt     <= taken ? 2'(FLUSH_CYCLES) : (flush_cnt != 2'd0) ? flush_cnt - 2'd1 : flush_cnt;
            id_ex_valid   <= live;
            id_ex_opcode  <= opcode;
            id_ex_funct   <= if_id_instr[5:0];
            id_ex_rs_val  <= rs_val;
            id_ex_rt_val  <= rt_val;
            id_ex_imm     <= imm;
            id_ex_rd      <= live ? dest : 5'd0;
            id_ex_NPC     <= if_id_NPC;
            id_ex_illegal <= live && illegal;
        end
    end
endmodule

// File: tb/tb_inst_decode.sv
// tb_inst_decode: directed scoreboard bench for inst_decode.
module tb_inst_decode;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] if_id_instr = '0;
    logic [9:0]  if_id_NPC = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        PCSrc, id_ex_valid, id_ex_illegal;
    logic [9:0]  Ex_NPC, id_ex_NPC;
    logic [5:0]  id_ex_opcode, id_ex_funct;
    logic [31:0] id_ex_rs_val, id_ex_rt_val, id_ex_imm;
    logic [4:0]  id_ex_rd;
    int          vectors = 0;
    int          miscompares = 0;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  npc;
        logic        valid;
        logic [4:0]  rd;
        logic        ill;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic        pcsrc;
        logic [9:0]  ex_npc;
    } exp_t;

    exp_t sb[$];

    inst_decode #(.FLUSH_CYCLES(2), .PC_W(10)) dut (
        .clk(clk), .rst(rst),
        .if_id_instr(if_id_instr), .if_id_NPC(if_id_NPC),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .PCSrc(PCSrc), .Ex_NPC(Ex_NPC),
        .id_ex_valid(id_ex_valid), .id_ex_opcode(id_ex_opcode), .id_ex_funct(id_ex_funct),
        .id_ex_rs_val(id_ex_rs_val), .id_ex_rt_val(id_ex_rt_val), .id_ex_imm(id_ex_imm),
        .id_ex_rd(id_ex_rd), .id_ex_NPC(id_ex_NPC), .id_ex_illegal(id_ex_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input int op, input int rs, input int rt, input logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drive one instruction, queue what ID/EX must hold after the next edge, then check it
    task automatic step(input logic [31:0] instr, input logic [9:0] npc,
                        input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                        input logic v, input logic [4:0] rd, input logic ill,
                        input logic [31:0] rsv, input logic [31:0] rtv,
                        input logic pc, input logic [9:0] en, input string tag);
        exp_t e;
        if_id_instr = instr;
        if_id_NPC   = npc;
        wb_en       = wen;
        wb_addr     = wa;
        wb_data     = wd;
        sb.push_back('{instr, npc, v, rd, ill, rsv, rtv, pc, en});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".valid"},   32'(id_ex_valid),   32'(e.valid));
        chk({tag, ".rd"},      32'(id_ex_rd),      32'(e.rd));
        chk({tag, ".illegal"}, 32'(id_ex_illegal), 32'(e.ill));
        chk({tag, ".rs_val"},  id_ex_rs_val,       e.rsv);
        chk({tag, ".rt_val"},  id_ex_rt_val,       e.rtv);
        chk({tag, ".PCSrc"},   32'(PCSrc),         32'(e.pcsrc));
        chk({tag, ".Ex_NPC"},  32'(Ex_NPC),        32'(e.ex_npc));
        chk({tag, ".opcode"},  32'(id_ex_opcode),  32'(e.instr[31:26]));
        chk({tag, ".funct"},   32'(id_ex_funct),   32'(e.instr[5:0]));
        chk({tag, ".imm"},     id_ex_imm,          {{16{e.instr[15]}}, e.instr[15:0]});
        chk({tag, ".NPC"},     32'(id_ex_NPC),     32'(e.npc));
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({PCSrc, Ex_NPC, id_ex_valid, id_ex_rd, id_ex_illegal} != 0), 32'd0);
        chk("reset_ops", id_ex_rs_val | id_ex_rt_val | id_ex_imm, 32'd0);
        rst = 1'b1;
        //   instr                                npc     wen wa  wd            v  rd ill rs_val        rt_val        pc ex_npc
        step(enc(1, 0, 1, 16'h0005),             10'd3,   0, 0,  32'd0,        1, 1, 0,  32'd0,        32'd0,        0, 10'd0,   "addi_r1");
        step(enc(0, 2, 1, {5'd4, 5'd0, 6'h20}),  10'd4,   1, 2,  32'hDEADBEEF, 1, 4, 0,  32'hDEADBEEF, 32'd0,        0, 10'd0,   "rtype_bypass");
        step(enc(0, 0, 2, {5'd5, 5'd0, 6'h21}),  10'd5,   1, 0,  32'h12345678, 1, 5, 0,  32'd0,        32'hDEADBEEF, 0, 10'd0,   "wr_r0");
        step(enc(1, 1, 6, 16'hFFFF),             10'd6,   1, 1,  32'd7,        1, 6, 0,  32'd7,        32'd0,        0, 10'd0,   "addi_neg");
        step(enc(4, 3, 0, 16'h0004),             10'h3FE, 0, 0,  32'd0,        1, 0, 0,  32'd0,        32'd0,        1, 10'h002, "bz_wrap");
        step(enc(1, 1, 7, 16'h0001),             10'd3,   0, 0,  32'd0,        0, 0, 0,  32'd7,        32'd0,        0, 10'h002, "bz_sq1");
        step(enc(63, 0, 0, 16'h0000),            10'd4,   0, 0,  32'd0,        0, 0, 0,  32'd0,        32'd0,        0, 10'h002, "bz_sq2");
        step(enc(1, 0, 8, 16'h0009),             10'd5,   0, 0,  32'd0,        1, 8, 0,  32'd0,        32'd0,        0, 10'h002, "bz_live");
        step(enc(5, 0, 0, 16'h0003),             10'd6,   0, 0,  32'd0,        1, 0, 0,  32'd0,        32'd0,        0, 10'h002, "bnz_nt");
        step(enc(6, 0, 0, 16'h0155),             10'd7,   0, 0,  32'd0,        1, 0, 0,  32'd0,        32'd0,        1, 10'h155, "b_taken");
        step(enc(6, 0, 0, 16'h00AA),             10'h156, 0, 0,  32'd0,        0, 0, 0,  32'd0,        32'd0,        0, 10'h155, "b_shadow");
        step(enc(1, 0, 9, 16'h0001),             10'h157, 0, 0,  32'd0,        0, 0, 0,  32'd0,        32'd0,        0, 10'h155, "b_sq2");
        step(enc(63, 1, 0, 16'h8000),            10'h158, 0, 0,  32'd0,        1, 0, 1,  32'd7,        32'd0,        0, 10'h155, "illegal");
        step(enc(5, 1, 0, 16'h03FF),             10'h010, 0, 0,  32'd0,        1, 0, 0,  32'd7,        32'd0,        1, 10'h00F, "bnz_wrap");
        step(enc(1, 0, 10, 16'h0002),            10'h011, 0, 0,  32'd0,        0, 0, 0,  32'd0,        32'd0,        0, 10'h00F, "bnz_sq1");
        #2 rst = 1'b0;
        #1;
        chk("midflush_outputs", 32'({PCSrc, Ex_NPC, id_ex_valid, id_ex_rd, id_ex_illegal, id_ex_NPC} != 0), 32'd0);
        chk("midflush_ops", id_ex_rs_val | id_ex_rt_val | id_ex_imm | 32'(id_ex_opcode), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(enc(1, 0, 1, 16'h0005),             10'd3,   0, 0,  32'd0,        1, 1, 0,  32'd0,        32'd0,        0, 10'd0,   "post_reset");
        step(enc(0, 1, 1, {5'd2, 5'd0, 6'h00}),  10'd4,   0, 0,  32'd0,        1, 2, 0,  32'd0,        32'd0,        0, 10'd0,   "regs_cleared");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
